// File: rtl/taillight_sequencer_pkg.sv
// Shared types and defaults for the taillight sequencer.
package taillight_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LEFT   = 2'd1,
    ST_RIGHT  = 2'd2,
    ST_HAZARD = 2'd3
  } state_t;

  localparam int unsigned DEF_N_LAMPS  = 3;
  localparam int unsigned DEF_STEP_DIV = 1;

  // Mode priority: hazard, then both turns together, then left, then right.
  function automatic state_t next_mode(input logic hazard,
                                       input logic turn_left,
                                       input logic turn_right);
    if (hazard || (turn_left && turn_right)) return ST_HAZARD;
    else if (turn_left)                      return ST_LEFT;
    else if (turn_right)                     return ST_RIGHT;
    else                                     return ST_IDLE;
  endfunction

endpackage

// File: rtl/taillight_sequencer_if.sv
// Request inputs and lamp outputs of the taillight sequencer.
interface taillight_sequencer_if #(
  parameter int unsigned N_LAMPS = 3
);
  logic               brake;
  logic               turn_left;
  logic               turn_right;
  logic               hazard;
  logic [N_LAMPS-1:0] left_lamps;
  logic [N_LAMPS-1:0] right_lamps;
  logic               seq_active;

  modport master (
    output brake, turn_left, turn_right, hazard,
    input  left_lamps, right_lamps, seq_active
  );

  modport slave (
    input  brake, turn_left, turn_right, hazard,
    output left_lamps, right_lamps, seq_active
  );
endinterface

// File: rtl/taillight_sequencer_step_ticker.sv
// Step prescaler: pulses o_tick for one cycle every STEP_DIV cycles.
module step_ticker #(
  parameter int unsigned STEP_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  output logic o_tick
);
  localparam int unsigned CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

  logic [CW-1:0] r_cnt;

  // Count 0..STEP_DIV-1, restarting on clear or at the last count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          r_cnt <= '0;
    else if (i_clear || r_cnt == LAST) r_cnt <= '0;
    else                              r_cnt <= r_cnt + CW'(1);
  end

  assign o_tick = (r_cnt == LAST) && !i_clear;
endmodule

// File: rtl/taillight_sequencer.sv
// Taillight sequencer: thermometer turn/hazard sequencing with brake fill.
module taillight_sequencer
  import taillight_pkg::*;
#(
  parameter int unsigned N_LAMPS  = DEF_N_LAMPS,
  parameter int unsigned STEP_DIV = DEF_STEP_DIV
) (
  input logic clk,
  input logic rst,
  taillight_sequencer_if.slave bus
);
  localparam int unsigned SW = $clog2(N_LAMPS + 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(N_LAMPS);

  state_t             r_state;
  state_t             w_next;
  logic [SW-1:0]      r_step;
  logic [SW-1:0]      w_step_nxt;
  logic               w_clear;
  logic               w_tick;
  logic [N_LAMPS-1:0] w_pattern;
  logic [N_LAMPS-1:0] w_brake_fill;
  logic [N_LAMPS-1:0] w_left;
  logic [N_LAMPS-1:0] w_right;
  logic               w_active;
  logic [N_LAMPS-1:0] r_left;
  logic [N_LAMPS-1:0] r_right;
  logic               r_active;

  step_ticker #(.STEP_DIV(STEP_DIV)) u_ticker (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_clear),
    .o_tick  (w_tick)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next-state selection, evaluated every edge; any mode change restarts the sequence.
  always_comb begin
    w_next  = next_mode(bus.hazard, bus.turn_left, bus.turn_right);
    w_clear = (w_next != r_state) || (w_next == ST_IDLE);
  end

  // Next step: cleared on entry, advanced on tick, wrapping after the dark step.
  always_comb begin
    w_step_nxt = r_step;
    if (w_clear)                w_step_nxt = '0;
    else if (w_tick)            w_step_nxt = (r_step == STEP_LAST) ? '0 : r_step + SW'(1);
  end

  // Step register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_step <= '0;
    else     r_step <= w_step_nxt;
  end

  // Outputs are computed from next state/step so the new step shows on the entry edge.
  always_comb begin
    w_pattern    = '0;
    for (int unsigned i = 0; i < N_LAMPS; i++)
      w_pattern[i] = (w_step_nxt != STEP_LAST) && (i <= 32'(w_step_nxt));
    w_brake_fill = bus.brake ? '1 : '0;
    w_left       = w_brake_fill;
    w_right      = w_brake_fill;
    w_active     = 1'b0;
    case (w_next)
      ST_LEFT:   begin w_left = w_pattern;                          w_active = 1'b1; end
      ST_RIGHT:  begin w_right = w_pattern;                         w_active = 1'b1; end
      ST_HAZARD: begin w_left = w_pattern; w_right = w_pattern;     w_active = 1'b1; end
      default:   ;
    endcase
  end

  // Registered lamp drive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_left   <= '0;
      r_right  <= '0;
      r_active <= 1'b0;
    end else begin
      r_left   <= w_left;
      r_right  <= w_right;
      r_active <= w_active;
    end
  end

  assign bus.left_lamps  = r_left;
  assign bus.right_lamps = r_right;
  assign bus.seq_active  = r_active;
endmodule

// File: tb/tb_taillight_sequencer.sv
// Directed testbench for taillight_sequencer (3 lamps/div 2 and 5 lamps/div 1).
module tb_taillight_sequencer;
  logic clk;
  logic rst;
  int   errors;
  int   checks;

  logic [2:0] seq3 [8] = '{3'b001, 3'b001, 3'b011, 3'b011, 3'b111, 3'b111, 3'b000, 3'b000};
  logic [4:0] seq5 [6] = '{5'b00001, 5'b00011, 5'b00111, 5'b01111, 5'b11111, 5'b00000};

  taillight_sequencer_if #(.N_LAMPS(3)) bus_a ();
  taillight_sequencer_if #(.N_LAMPS(5)) bus_b ();

  taillight_sequencer #(.N_LAMPS(3), .STEP_DIV(2)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  taillight_sequencer #(.N_LAMPS(5), .STEP_DIV(1)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string name, input logic [2:0] exp_l,
                       input logic [2:0] exp_r, input logic exp_act);
    checks++;
    if (bus_a.left_lamps !== exp_l || bus_a.right_lamps !== exp_r || bus_a.seq_active !== exp_act) begin
      errors++;
      $display("FAIL %s: got L=%b R=%b act=%b, want L=%b R=%b act=%b", name,
               bus_a.left_lamps, bus_a.right_lamps, bus_a.seq_active, exp_l, exp_r, exp_act);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus_a.brake = 0; bus_a.turn_left = 0; bus_a.turn_right = 0; bus_a.hazard = 0;
    bus_b.brake = 0; bus_b.turn_left = 0; bus_b.turn_right = 0; bus_b.hazard = 0;
    #1 rst = 1'b1;
    #1;
    chk_a("reset_async_a", 3'b000, 3'b000, 1'b0);
    checks++;
    if (bus_b.left_lamps !== 5'b0 || bus_b.right_lamps !== 5'b0 || bus_b.seq_active !== 1'b0) begin
      errors++;
      $display("FAIL reset_async_b: got L=%b R=%b act=%b, want 0", bus_b.left_lamps,
               bus_b.right_lamps, bus_b.seq_active);
    end
    bus_a.turn_left = 1;
    tick();
    chk_a("reset_held_edge", 3'b000, 3'b000, 1'b0);
    bus_a.turn_left = 0;
    rst = 1'b0;
    tick();
    chk_a("idle_after_reset", 3'b000, 3'b000, 1'b0);
  endtask

  task automatic test_left_seq();
    bus_a.turn_left = 1;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk_a($sformatf("left_seq[%0d]", i), seq3[i % 8], 3'b000, 1'b1);
    end
    bus_a.turn_left = 0;
    tick();
    chk_a("left_release", 3'b000, 3'b000, 1'b0);
  endtask

  task automatic test_brake_right();
    bus_a.brake = 1;
    tick();
    chk_a("brake_idle", 3'b111, 3'b111, 1'b0);
    bus_a.turn_right = 1;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) bus_a.brake = 0;
      if (i == 6) bus_a.brake = 1;
      tick();
      chk_a($sformatf("brake_right[%0d]", i),
            (i >= 4 && i < 6) ? 3'b000 : 3'b111, seq3[i], 1'b1);
    end
    bus_a.turn_right = 0;
    tick();
    chk_a("right_drop_brake", 3'b111, 3'b111, 1'b0);
    bus_a.brake = 0;
    tick();
    chk_a("brake_release", 3'b000, 3'b000, 1'b0);
  endtask

  task automatic test_switch();
    bus_a.turn_left = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_a($sformatf("switch_left[%0d]", i), seq3[i], 3'b000, 1'b1);
    end
    bus_a.turn_left = 0;
    bus_a.turn_right = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_a($sformatf("switch_right[%0d]", i), 3'b000, seq3[i], 1'b1);
    end
    bus_a.turn_right = 0;
    tick();
    chk_a("switch_release", 3'b000, 3'b000, 1'b0);
  endtask

  task automatic test_hazard();
    bus_a.brake = 1; bus_a.turn_left = 1; bus_a.hazard = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk_a($sformatf("hazard[%0d]", i), seq3[i], seq3[i], 1'b1);
    end
    // Both turns held stays in hazard without restarting.
    bus_a.hazard = 0; bus_a.turn_right = 1;
    for (int i = 8; i < 12; i++) begin
      tick();
      chk_a($sformatf("hazard_both[%0d]", i), seq3[i % 8], seq3[i % 8], 1'b1);
    end
    bus_a.turn_left = 0; bus_a.turn_right = 0;
    tick();
    chk_a("hazard_exit_brake", 3'b111, 3'b111, 1'b0);
    bus_a.brake = 0;
    tick();
    chk_a("hazard_idle", 3'b000, 3'b000, 1'b0);
  endtask

  task automatic test_reset_mid();
    bus_a.turn_right = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_a($sformatf("pre_rst_right[%0d]", i), 3'b000, seq3[i], 1'b1);
    end
    #2 rst = 1'b1;
    #1;
    chk_a("rst_mid_async", 3'b000, 3'b000, 1'b0);
    tick();
    chk_a("rst_mid_held", 3'b000, 3'b000, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_a($sformatf("post_rst_right[%0d]", i), 3'b000, seq3[i], 1'b1);
    end
    bus_a.turn_right = 0;
    tick();
    chk_a("post_rst_idle", 3'b000, 3'b000, 1'b0);
  endtask

  task automatic test_wide();
    bus_b.turn_right = 1;
    bus_b.brake = 1;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if (bus_b.right_lamps !== seq5[i % 6] || bus_b.left_lamps !== 5'b11111 || bus_b.seq_active !== 1'b1) begin
        errors++;
        $display("FAIL wide_right[%0d]: got L=%b R=%b act=%b, want L=11111 R=%b act=1", i,
                 bus_b.left_lamps, bus_b.right_lamps, bus_b.seq_active, seq5[i % 6]);
      end
    end
    bus_b.turn_right = 0;
    bus_b.brake = 0;
    tick();
    checks++;
    if (bus_b.right_lamps !== 5'b0 || bus_b.left_lamps !== 5'b0 || bus_b.seq_active !== 1'b0) begin
      errors++;
      $display("FAIL wide_idle: got L=%b R=%b act=%b, want 0", bus_b.left_lamps,
               bus_b.right_lamps, bus_b.seq_active);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_left_seq();
    test_brake_right();
    test_switch();
    test_hazard();
    test_reset_mid();
    test_wide();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/taillight_sequencer.md
TAILLIGHT_SEQUENCER -- requirements
Module: taillight_sequencer

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-002 Parameter N_LAMPS, default 3, lamps per side (legal 2..8).
REQ-003 Parameter STEP_DIV, default 1, clock cycles per sequence step (legal 1..65535).
REQ-004 clk  input  1  rising-edge system clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 brake  input  1  brake pedal, level.
REQ-007 turn_left  input  1  left turn request, level.
REQ-008 turn_right  input  1  right turn request, level.
REQ-009 hazard  input  1  hazard request, level.
REQ-010 left_lamps  output  N_LAMPS  left lamp drive, bit 0 innermost, registered.
REQ-011 right_lamps  output  N_LAMPS  right lamp drive, bit 0 innermost, registered.
REQ-012 seq_active  output  1  high while any side is sequencing, registered.

Function
REQ-013 The FSM SHALL have the states IDLE, LEFT, RIGHT and HAZARD.
REQ-014 Mode selection SHALL be evaluated at every edge with priority hazard > (turn_left and turn_right) -> HAZARD > turn_left -> LEFT > turn_right -> RIGHT > none -> IDLE.
REQ-015 The sequence SHALL have N_LAMPS+1 steps: step k (0..N_LAMPS-1) drives bits [k:0] high (thermometer); step N_LAMPS drives all zeros; step N_LAMPS then wraps to step 0.
REQ-016 Each step SHALL last exactly STEP_DIV cycles; the full period SHALL be (N_LAMPS+1)*STEP_DIV cycles.
REQ-017 On any state change into LEFT, RIGHT or HAZARD, the step counter and prescaler SHALL clear, and step 0 (value 1) SHALL appear on the outputs after the first edge at which the new request is sampled.
REQ-018 LEFT: left_lamps follows the sequence; right_lamps = all ones if brake, else zero.
REQ-019 RIGHT: mirror of REQ-018.
REQ-020 HAZARD: both sides SHALL show the identical step in lockstep; brake SHALL be ignored.
REQ-021 IDLE: both sides = all ones if brake, else zero; seq_active = 0.
REQ-022 The sequencing side SHALL ignore brake, including during the all-zero step.
REQ-023 A brake change SHALL affect only the non-sequencing side, one edge later, without disturbing step or prescaler.
REQ-024 Direct LEFT<->RIGHT transitions SHALL restart at step 0 on the new side; the old side SHALL follow REQ-018/019 on the same edge.
REQ-025 seq_active SHALL be 1 in LEFT, RIGHT and HAZARD.
REQ-026 With STEP_DIV = 1, the step SHALL advance every cycle.

Reset
REQ-027 While rst is high, the outputs SHALL be: state IDLE, left_lamps = 0, right_lamps = 0, seq_active = 0, step = 0, prescaler = 0, independent of clk.
REQ-028 After rst deasserts, the first edge SHALL evaluate the inputs per REQ-014; a held turn input SHALL start at step 0.
REQ-029 Reset asserted mid-sequence SHALL abort it immediately, with no completion of the current step.

Structure
REQ-030 Shared package taillight_pkg SHALL hold the FSM state enum and the default parameter constants.
REQ-031 The prescaler SHALL be a sub-module step_ticker with parameter STEP_DIV, a synchronous clear input, and a one-cycle tick output.
REQ-032 The step counter width SHALL be clog2(N_LAMPS+1); the prescaler width SHALL be clog2(STEP_DIV) (minimum 1).

Verification (N_LAMPS=3, STEP_DIV=2 unless stated)
REQ-033 turn_left held 16 cycles -> left_lamps 001,001,011,011,111,111,000,000 repeating; right_lamps = 000.
REQ-034 brake then turn_right -> left_lamps = 111 constant; right_lamps sequences from 001; drop turn_right -> right_lamps = 111 next edge.
REQ-035 turn_left for 5 cycles, then switch to turn_right -> right_lamps = 001 on the next edge; left_lamps = 000.
REQ-036 hazard with brake and turn_left -> both sides show the identical sequence; seq_active = 1.
REQ-037 rst pulse mid-step during turn_right -> outputs = 000 asynchronously; after release, right_lamps = 001 at the first edge.
REQ-038 N_LAMPS=5, STEP_DIV=1, turn_right -> 00001,00011,00111,01111,11111,00000 with period 6.
